if_prefetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage for a request/response (SRAM-like) instruction bus.

---
 rtl/if_prefetch_stage_pkg.sv | 26 ++
 rtl/if_inst_buf.sv | 59 +++++
 rtl/if_prefetch_stage.sv | 166 ++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Shared widths, exception codes and FSM encodings
// for the prefetching instruction-fetch stage.
package if_prefetch_stage_pkg;

   localparam int BR_BUS_WD       = 33;
   localparam int FS_TO_DS_BUS_WD = 72;
   localparam int WS_TO_FS_BUS_WD = 67;

   localparam logic [5:0]  ECODE_ADE     = 6'h08;
   localparam logic        ESUBCODE_ADEF = 1'b0;
   localparam logic [31:0] ADEF_INST     = 32'h0010_0000;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } fs_state_e;

   typedef struct packed {
      logic        esubcode;
      logic [5:0]  ecode;
      logic        ex;
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_to_ds_t;

endpackage

// File: rtl/if_inst_buf.sv
// Synchronous FIFO with flush; push is accepted
// when full if a pop happens in the same cycle.
module if_inst_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    wr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_pop;
   logic             do_push;

   function automatic logic [AW-1:0] ptr_inc(
      input logic [AW-1:0] p
   );
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i &&
                    ((cnt_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_inc(wr_q);
         if (do_pop)  rd_q <= ptr_inc(rd_q);
         if (do_push && !do_pop)
            cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Fetch stage: pipelined SRAM-like requests, pc tag
// queue, instruction buffer and redirect cancellation.
module if_prefetch_stage
   import if_prefetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
   parameter int          IB_DEPTH        = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ds_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   input  logic [WS_TO_FS_BUS_WD-1:0] ws_to_fs_bus,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       inst_sram_req,
   output logic                       inst_sram_wr,
   output logic [1:0]                 inst_sram_size,
   output logic [31:0]                inst_sram_addr,
   input  logic                       inst_sram_addr_ok,
   input  logic                       inst_sram_data_ok,
   input  logic [31:0]                inst_sram_rdata
);

   localparam int IW = $clog2(IB_DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int CW = IW + 1;

   fs_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [OW-1:0] cancel_q, cancel_d;

   logic        br_taken, final_ex, ertn_flush;
   logic [31:0] br_target, ex_era, ex_entry;
   logic        redirect;
   logic [31:0] target;
   logic        unused_has_int;

   logic [IW-1:0] ib_cnt;
   logic [OW-1:0] out_cnt;
   logic [CW-1:0] inflight;
   logic [31:0]   tag_pc;
   logic          issue, resp_push, adef_push;
   logic          ib_push, ib_pop;
   fs_to_ds_t     ib_din, ib_head;

   assign br_taken       = br_bus[32];
   assign br_target      = br_bus[31:0];
   assign unused_has_int = ws_to_fs_bus[66];
   assign ex_era         = ws_to_fs_bus[65:34];
   assign ex_entry       = ws_to_fs_bus[33:2];
   assign final_ex       = ws_to_fs_bus[1];
   assign ertn_flush     = ws_to_fs_bus[0];

   // Exceptions/ertn override a branch in the same cycle
   assign redirect = final_ex | br_taken;
   assign target   = final_ex ?
                     (ertn_flush ? ex_era : ex_entry) :
                     br_target;

   assign inflight = CW'(ib_cnt) + CW'(out_cnt);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:  if (adef_push) state_d = S_HALT;
         S_HALT: state_d = S_HALT;
      endcase
      if (redirect) state_d = S_RUN;
   end

   always_comb begin
      inst_sram_req = 1'b0;
      adef_push     = 1'b0;
      if (state_q == S_RUN && !redirect && !reset) begin
         if (pc_q[1:0] != 2'b00)
            adef_push = (out_cnt == '0) &&
                        (ib_cnt < IW'(IB_DEPTH));
         else
            inst_sram_req =
               (out_cnt < OW'(MAX_OUTSTANDING)) &&
               (inflight < CW'(IB_DEPTH));
      end
   end

   assign issue = inst_sram_req & inst_sram_addr_ok;

   // Every in-flight request, counted or not, goes stale
   always_comb begin
      cancel_d = cancel_q;
      if (redirect)
         cancel_d = out_cnt - OW'(inst_sram_data_ok);
      else if (inst_sram_data_ok && cancel_q != '0)
         cancel_d = cancel_q - 1'b1;
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect)   pc_d = target;
      else if (issue) pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         cancel_q <= '0;
      end else begin
         pc_q     <= pc_d;
         cancel_q <= cancel_d;
      end
   end

   assign resp_push = inst_sram_data_ok &&
                      cancel_q == '0 && !redirect;
   assign ib_push   = resp_push | adef_push;
   assign ib_pop    = fs_to_ds_valid & ds_allowin;

   always_comb begin
      ib_din = '{1'b0, 6'h0, 1'b0,
                 inst_sram_rdata, tag_pc};
      if (adef_push)
         ib_din = '{ESUBCODE_ADEF, ECODE_ADE, 1'b1,
                    ADEF_INST, pc_q};
   end

   if_inst_buf #(
      .WIDTH (32),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_q (
      .clk     (clk),
      .reset   (reset),
      .flush_i (1'b0),
      .push_i  (issue),
      .data_i  (pc_q),
      .pop_i   (inst_sram_data_ok),
      .data_o  (tag_pc),
      .count_o (out_cnt)
   );

   if_inst_buf #(
      .WIDTH (FS_TO_DS_BUS_WD),
      .DEPTH (IB_DEPTH)
   ) u_ib (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect),
      .push_i  (ib_push),
      .data_i  (ib_din),
      .pop_i   (ib_pop),
      .data_o  (ib_head),
      .count_o (ib_cnt)
   );

   assign fs_to_ds_valid = (ib_cnt != '0) && !redirect;
   assign fs_to_ds_bus   = fs_to_ds_valid ? ib_head : '0;
   assign inst_sram_wr   = 1'b0;
   assign inst_sram_size = 2'd2;
   assign inst_sram_addr = pc_q;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench: in-order memory model, expected decode
// entries queued when responses/redirects are driven.
module tb_if_prefetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic [32:0] br_bus;
   logic [66:0] ws_to_fs_bus;
   logic        fs_to_ds_valid;
   logic [71:0] fs_to_ds_bus;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   always #5 clk = ~clk;

   if_prefetch_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ds_allowin        (ds_allowin),
      .br_bus            (br_bus),
      .ws_to_fs_bus      (ws_to_fs_bus),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } pend_t;

   pend_t       pend[$];
   logic [71:0] exp_q[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_deliv = 0;
   logic [31:0] exp_pc = 32'h1c00_0000;
   bit          halted = 0;
   bit          first_pending = 0;
   logic [71:0] first_bus = '0;

   bit          allow, aok, dok;
   logic [32:0] br;
   logic [66:0] ws;

   task automatic chk(input string tag,
                      input logic [71:0] got,
                      input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      logic        redir;
      logic [31:0] tgt;
      pend_t       p;
      ds_allowin        = allow;
      inst_sram_addr_ok = aok;
      br_bus            = br;
      ws_to_fs_bus      = ws;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = '0;
      if (dok && pend.size() > 0) begin
         inst_sram_data_ok = 1'b1;
         inst_sram_rdata   = ~pend[0].addr;
      end
      @(negedge clk);
      redir = br[32] | ws[1];
      tgt   = ws[1] ? (ws[0] ? ws[65:34] : ws[33:2])
                    : br[31:0];
      if (redir) begin
         chk("redir_noreq", 72'(inst_sram_req), 72'(0));
         chk("redir_vld", 72'(fs_to_ds_valid), 72'(0));
      end
      if (halted)
         chk("halt_noreq", 72'(inst_sram_req), 72'(0));
      if (fs_to_ds_valid && allow) begin
         n_deliv++;
         if (first_pending) begin
            first_bus     = fs_to_ds_bus;
            first_pending = 0;
         end
         if (exp_q.size() == 0)
            chk("extra_deliv", 72'(fs_to_ds_valid), 72'(0));
         else
            chk("deliv", fs_to_ds_bus, exp_q.pop_front());
      end
      if (inst_sram_data_ok) begin
         p = pend.pop_front();
         if (!p.stale && !redir)
            exp_q.push_back({1'b0, 6'h0, 1'b0,
                             ~p.addr, p.addr});
      end
      if (inst_sram_req && aok) begin
         chk("req_addr", 72'(inst_sram_addr), 72'(exp_pc));
         pend.push_back('{inst_sram_addr, 1'b0});
         exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_q.delete();
         exp_pc        = tgt;
         first_pending = 1;
         first_bus     = '0;
         halted        = (tgt[1:0] != 2'b00);
         if (halted)
            exp_q.push_back({1'b0, 6'h08, 1'b1,
                             32'h0010_0000, tgt});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic drain();
      int k = 0;
      allow = 1; aok = 0; dok = 1; br = '0; ws = '0;
      while ((pend.size() > 0 || exp_q.size() > 0)
             && k < 60) begin
         tick();
         k++;
      end
      chk("drain", 72'(pend.size() + exp_q.size()), 72'(0));
   endtask

   int d0;

   initial begin
      reset = 1'b1;
      allow = 0; aok = 0; dok = 0;
      br = '0; ws = '0;
      ds_allowin = 0; br_bus = '0; ws_to_fs_bus = '0;
      inst_sram_addr_ok = 0; inst_sram_data_ok = 0;
      inst_sram_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", 72'(fs_to_ds_valid), 72'(0));
      chk("rst_req", 72'(inst_sram_req), 72'(0));
      chk("rst_bus", fs_to_ds_bus, 72'(0));
      chk("rst_wr", 72'(inst_sram_wr), 72'(0));
      chk("rst_size", 72'(inst_sram_size), 72'(2));
      reset = 1'b0;

      // streaming at full rate
      allow = 1; aok = 1; dok = 1;
      run(5);
      d0 = n_deliv;
      run(10);
      chk("t1_rate", 72'(n_deliv - d0), 72'(10));

      // decode stalled: buffer fills, requests stop
      allow = 0;
      run(10);
      chk("t2_full", 72'(exp_q.size()), 72'(4));
      chk("t2_req", 72'(inst_sram_req), 72'(0));
      drain();

      // branch with two requests in flight
      allow = 1; aok = 1; dok = 0;
      run(3);
      chk("t3_out", 72'(pend.size()), 72'(2));
      br = {1'b1, 32'h1c00_0100};
      tick();
      br = '0; dok = 1;
      run(8);
      chk("t3_first", 72'(first_bus[31:0]),
          72'(32'h1c00_0100));
      drain();

      // exception while the buffer holds three entries
      allow = 0; aok = 1; dok = 1;
      run(8);
      allow = 1; aok = 0;
      tick();
      chk("t4_vld_pre", 72'(fs_to_ds_valid), 72'(1));
      ws = {1'b0, 32'h0, 32'h1c00_8000, 1'b1, 1'b0};
      aok = 1;
      tick();
      ws = '0;
      run(8);
      chk("t4_first", 72'(first_bus[31:0]),
          72'(32'h1c00_8000));
      drain();

      // misaligned branch target -> ADEF, halt, ertn
      allow = 1; aok = 1; dok = 1;
      run(3);
      br = {1'b1, 32'h1c00_0102};
      tick();
      br = '0;
      run(10);
      chk("t5_adef", first_bus,
          {1'b0, 6'h08, 1'b1, 32'h0010_0000,
           32'h1c00_0102});
      chk("t5_halt", 72'(inst_sram_req), 72'(0));
      ws = {1'b0, 32'h1c00_0200, 32'h1c00_ee00,
            1'b1, 1'b1};
      tick();
      ws = '0;
      run(8);
      chk("t5_resume", 72'(first_bus[31:0]),
          72'(32'h1c00_0200));
      drain();

      // redirect coincident with a response
      allow = 1; aok = 1; dok = 0;
      run(3);
      dok = 1;
      br = {1'b1, 32'h1c00_0300};
      tick();
      br = '0;
      run(8);
      chk("t6_first", 72'(first_bus[31:0]),
          72'(32'h1c00_0300));
      drain();

      // back-to-back redirects: later one wins
      allow = 1; aok = 1; dok = 0;
      run(3);
      br = {1'b1, 32'h1c00_0400};
      tick();
      br = {1'b1, 32'h1c00_0500};
      tick();
      br = '0; dok = 1;
      run(8);
      chk("t7_first", 72'(first_bus[31:0]),
          72'(32'h1c00_0500));
      drain();

      // counters back to idle
      aok = 0;
      tick();
      chk("idle_req", 72'(inst_sram_req), 72'(1));
      aok = 1;
      run(6);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
